// File: rtl/rpn_exec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : rpn_exec                                                          |
// | Brief  : RPN command executor between UART RX/TX and an external stack.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module rpn_exec #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             stk_wen,
  output logic [WIDTH-1:0] stk_din,
  output logic [1:0]       stk_pop_cnt,
  input  logic [WIDTH-1:0] stk_first,
  input  logic [WIDTH-1:0] stk_second,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  input  logic             res_ready,
  output logic             err
);

  localparam int DEPTH_W = $clog2(DEPTH + 1);

  localparam logic [WIDTH-1:0]   c_ten       = WIDTH'(10);
  localparam logic [DEPTH_W-1:0] c_one       = DEPTH_W'(1);
  localparam logic [DEPTH_W-1:0] c_two       = DEPTH_W'(2);
  localparam logic [DEPTH_W-1:0] c_depth_max = DEPTH_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NUM  = 3'd1,
    S_WAIT = 3'd2,
    S_OP   = 3'd3,
    S_EMIT = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    P_NONE = 3'd0,
    P_ADD  = 3'd1,
    P_SUB  = 3'd2,
    P_MUL  = 3'd3,
    P_EQ   = 3'd4
  } pend_t;

  state_t             state_q, state_d;
  pend_t              pend_q, pend_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               wen_q, wen_d;
  logic [WIDTH-1:0]   din_q, din_d;
  logic [1:0]         pop_q, pop_d;
  logic               res_valid_q, res_valid_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic               err_q, err_d;

  logic             w_accept;
  logic             w_is_digit;
  logic             w_is_delim;
  logic             w_is_clear;
  pend_t            w_op;
  pend_t            w_exec_op;
  logic [WIDTH-1:0] w_digit;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_prod;

  assign rx_ready    = (state_q == S_IDLE) || (state_q == S_NUM);
  assign w_accept    = rx_valid && rx_ready;
  assign stk_wen     = wen_q;
  assign stk_din     = din_q;
  assign stk_pop_cnt = pop_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign err         = err_q;

  // All arithmetic wraps modulo 2^WIDTH; only the low product bits are kept.
  assign w_sum  = stk_second + stk_first;
  assign w_diff = stk_second - stk_first;
  assign w_prod = stk_second * stk_first;

  always_comb begin
    w_is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    w_is_delim = (rx_data == 8'h20) || (rx_data == 8'h0D) || (rx_data == 8'h0A);
    w_is_clear = (rx_data == 8'h63);
    w_digit    = {{(WIDTH-4){1'b0}}, rx_data[3:0]};
    case (rx_data)
      8'h2B:   w_op = P_ADD;
      8'h2D:   w_op = P_SUB;
      8'h2A:   w_op = P_MUL;
      8'h3D:   w_op = P_EQ;
      default: w_op = P_NONE;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    acc_d       = acc_q;
    depth_d     = depth_q;
    wen_d       = 1'b0;
    din_d       = din_q;
    pop_d       = 2'd0;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    err_d       = err_q;
    w_exec_op   = P_NONE;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_digit) begin
            acc_d   = w_digit;
            state_d = S_NUM;
          end else if (w_is_clear) begin
            depth_d = '0;
            err_d   = 1'b0;
            acc_d   = '0;
          end else begin
            w_exec_op = w_op;
          end
        end
      end

      S_NUM: begin
        if (w_accept) begin
          if (w_is_digit) begin
            acc_d = acc_q * c_ten + w_digit;
          end else if (w_is_clear) begin
            depth_d = '0;
            err_d   = 1'b0;
            acc_d   = '0;
            state_d = S_IDLE;
          end else if (w_is_delim || (w_op != P_NONE)) begin
            // Push the literal; a trailing operator is parked until the push lands.
            if (depth_q == c_depth_max) begin
              err_d   = 1'b1;
              acc_d   = '0;
              pend_d  = P_NONE;
              state_d = S_IDLE;
            end else begin
              wen_d   = 1'b1;
              din_d   = acc_q;
              depth_d = depth_q + c_one;
              pend_d  = w_op;
              state_d = S_WAIT;
            end
          end
        end
      end

      S_WAIT: begin
        acc_d   = '0;
        state_d = (pend_q != P_NONE) ? S_OP : S_IDLE;
      end

      S_OP: begin
        w_exec_op = pend_q;
        pend_d    = P_NONE;
        state_d   = S_IDLE;
      end

      S_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Operator evaluation shared by IDLE (direct) and OP (deferred).
    case (w_exec_op)
      P_ADD, P_SUB, P_MUL: begin
        if (depth_q < c_two) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wen_d   = 1'b1;
          pop_d   = 2'd2;
          depth_d = depth_q - c_one;
          state_d = S_WAIT;
          case (w_exec_op)
            P_ADD:   din_d = w_sum;
            P_SUB:   din_d = w_diff;
            default: din_d = w_prod;
          endcase
        end
      end
      P_EQ: begin
        if (depth_q == '0) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          res_data_d  = stk_first;
          res_valid_d = 1'b1;
          state_d     = S_EMIT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= P_NONE;
      acc_q       <= '0;
      depth_q     <= '0;
      wen_q       <= 1'b0;
      din_q       <= '0;
      pop_q       <= 2'd0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      acc_q       <= acc_d;
      depth_q     <= depth_d;
      wen_q       <= wen_d;
      din_q       <= din_d;
      pop_q       <= pop_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      err_q       <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rpn_exec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_rpn_exec                                                       |
// | Brief  : Bench for rpn_exec with a behavioural stack and RPN calculator.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_rpn_exec;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             rx_valid = 1'b0;
  logic [7:0]       rx_data = 8'h00;
  logic             rx_ready;
  logic             stk_wen;
  logic [WIDTH-1:0] stk_din;
  logic [1:0]       stk_pop_cnt;
  logic [WIDTH-1:0] stk_first = '0;
  logic [WIDTH-1:0] stk_second = '0;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ready = 1'b0;
  logic             err;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;  // 0: hold low, 1: always high, 2: random

  rpn_exec #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .stk_wen    (stk_wen),
    .stk_din    (stk_din),
    .stk_pop_cnt(stk_pop_cnt),
    .stk_first  (stk_first),
    .stk_second (stk_second),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Behavioural stack: pops then push on the edge where the command is held.
  logic [WIDTH-1:0] stk_q[$];
  always @(posedge clk) begin
    for (int i = 0; i < int'(stk_pop_cnt); i++)
      if (stk_q.size() > 0) void'(stk_q.pop_front());
    if (stk_wen) stk_q.push_front(stk_din);
    stk_first  <= (stk_q.size() > 0) ? stk_q[0] : '0;
    stk_second <= (stk_q.size() > 1) ? stk_q[1] : '0;
  end

  // Observed command / result streams, sampled on the falling edge.
  logic [WIDTH+2:0] cmd_log[$];
  logic [WIDTH-1:0] res_log[$];
  always @(negedge clk) begin
    case (ready_mode)
      0:       res_ready = 1'b0;
      1:       res_ready = 1'b1;
      default: res_ready = ($urandom_range(0, 3) != 0);
    endcase
    if (!rst && res_valid && res_ready) res_log.push_back(res_data);
    if (!rst && (stk_wen || stk_pop_cnt != 2'd0)) cmd_log.push_back({stk_wen, stk_pop_cnt, stk_din});
  end

  // Reference calculator: a plain RPN evaluator over an integer stack.
  int               mstk[$];
  int unsigned      macc;
  bit               mnum;
  bit               merr;
  logic [WIDTH+2:0] exp_cmd[$];
  logic [WIDTH-1:0] exp_res[$];

  function automatic void model_reset();
    mstk.delete();
    macc = 0;
    mnum = 0;
    merr = 0;
  endfunction

  function automatic bit model_push();
    if (mstk.size() >= DEPTH) begin
      merr = 1;
      macc = 0;
      mnum = 0;
      return 0;
    end
    mstk.push_back(int'(macc));
    exp_cmd.push_back({1'b1, 2'd0, macc[WIDTH-1:0]});
    macc = 0;
    mnum = 0;
    return 1;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int     a, c;
    longint r;
    if (b >= 8'h30 && b <= 8'h39) begin
      macc = (macc * 10 + int'(b - 8'h30)) % 65536;
      mnum = 1;
    end else if (b == 8'h20 || b == 8'h0D || b == 8'h0A) begin
      if (mnum) void'(model_push());
    end else if (b == 8'h63) begin
      model_reset();
    end else if (b == 8'h2B || b == 8'h2D || b == 8'h2A || b == 8'h3D) begin
      if (mnum && !model_push()) return;
      if (b == 8'h3D) begin
        if (mstk.size() == 0) merr = 1;
        else exp_res.push_back(WIDTH'(mstk[$]));
      end else if (mstk.size() < 2) begin
        merr = 1;
      end else begin
        a = mstk.pop_back();
        c = mstk.pop_back();
        if (b == 8'h2B)      r = longint'(c) + longint'(a);
        else if (b == 8'h2D) r = longint'(c) - longint'(a);
        else                 r = longint'(c) * longint'(a);
        r = r & 64'hFFFF;
        mstk.push_back(int'(r));
        exp_cmd.push_back({1'b1, 2'd2, r[WIDTH-1:0]});
      end
    end
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rx_ready) begin
      errors++;
      $display("FAIL send_timeout byte=%02h rx_ready=%b required 1", b, rx_ready);
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (rx_ready && !res_valid) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 3) begin
      errors++;
      $display("FAIL %s idle_timeout rx_ready=%b res_valid=%b required 1/0", name, rx_ready, res_valid);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    cmd_log.delete();
    res_log.delete();
  endtask

  task automatic begin_run();
    cmd_log.delete();
    res_log.delete();
    exp_cmd.delete();
    exp_res.delete();
  endtask

  task automatic end_run(input string name);
    wait_idle(name);
    checks++;
    if (cmd_log.size() != exp_cmd.size()) begin
      errors++;
      $display("FAIL %s cmd_count got %0d required %0d", name, cmd_log.size(), exp_cmd.size());
    end
    for (int i = 0; i < cmd_log.size() && i < exp_cmd.size(); i++) begin
      checks++;
      if (cmd_log[i] !== exp_cmd[i]) begin
        errors++;
        $display("FAIL %s cmd[%0d] got wen/pop/din=%h required %h", name, i, cmd_log[i], exp_cmd[i]);
      end
    end
    checks++;
    if (res_log.size() != exp_res.size()) begin
      errors++;
      $display("FAIL %s res_count got %0d required %0d", name, res_log.size(), exp_res.size());
    end
    for (int i = 0; i < res_log.size() && i < exp_res.size(); i++) begin
      checks++;
      if (res_log[i] !== exp_res[i]) begin
        errors++;
        $display("FAIL %s res[%0d] got %h required %h", name, i, res_log[i], exp_res[i]);
      end
    end
    checks++;
    if (err !== merr) begin
      errors++;
      $display("FAIL %s err got %b required %b", name, err, merr);
    end
  endtask

  task automatic run_string(input string s, input string name);
    logic [7:0] b;
    begin_run();
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      model_byte(b);
      send_byte(b);
    end
    end_run(name);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (rx_ready !== 1'b1)       begin errors++; $display("FAIL reset_rx_ready got %b required 1", rx_ready); end
    if (stk_wen !== 1'b0)        begin errors++; $display("FAIL reset_stk_wen got %b required 0", stk_wen); end
    if (stk_din !== '0)          begin errors++; $display("FAIL reset_stk_din got %h required 0", stk_din); end
    if (stk_pop_cnt !== 2'd0)    begin errors++; $display("FAIL reset_pop_cnt got %0d required 0", stk_pop_cnt); end
    if (res_valid !== 1'b0)      begin errors++; $display("FAIL reset_res_valid got %b required 0", res_valid); end
    if (res_data !== '0)         begin errors++; $display("FAIL reset_res_data got %h required 0", res_data); end
    if (err !== 1'b0)            begin errors++; $display("FAIL reset_err got %b required 0", err); end
  endtask

  task automatic test_add();
    do_reset();
    run_string("12 34+=", "add");
    checks++;
    if (res_log.size() != 1 || res_log[0] !== 16'd46) begin
      errors++;
      $display("FAIL add_result got n=%0d v=%0d required n=1 v=46", res_log.size(), res_log[0]);
    end
  endtask

  task automatic test_sub_wrap();
    do_reset();
    run_string("5 7-=", "sub_wrap");
    checks++;
    if (res_log.size() != 1 || res_log[0] !== 16'hFFFE) begin
      errors++;
      $display("FAIL sub_wrap_result got %h required fffe", res_log[0]);
    end
    run_string("=", "sub_depth1_eq");
    run_string("+", "sub_depth1_underflow");
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL sub_underflow_err got %b required 1", err); end
  endtask

  task automatic test_mul();
    do_reset();
    run_string("300 300*=", "mul");
    checks++;
    if (res_log.size() != 1 || res_log[0] !== 16'd24464) begin
      errors++;
      $display("FAIL mul_result got %0d required 24464", res_log[0]);
    end
    run_string("c65536 =", "push_wrap");
    checks++;
    if (res_log.size() != 1 || res_log[0] !== 16'd0) begin
      errors++;
      $display("FAIL push_wrap_result got %0d required 0", res_log[0]);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    run_string("+=", "underflow");
    checks++;
    if (err !== 1'b1 || cmd_log.size() != 0) begin
      errors++;
      $display("FAIL underflow got err=%b cmds=%0d required err=1 cmds=0", err, cmd_log.size());
    end
    run_string("c", "clear");
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL clear_err got %b required 0", err); end
    run_string("=c", "clear_depth0");
  endtask

  task automatic test_overflow();
    string s = "";
    do_reset();
    for (int i = 0; i <= DEPTH; i++) s = {s, "1 "};
    run_string(s, "overflow");
    checks++;
    if (err !== 1'b1 || cmd_log.size() != DEPTH) begin
      errors++;
      $display("FAIL overflow got err=%b pushes=%0d required err=1 pushes=%0d", err, cmd_log.size(), DEPTH);
    end
    run_string("2 =", "overflow_full_eq");
    run_string("+=c", "overflow_then_add");
  endtask

  task automatic test_latency();
    do_reset();
    begin_run();
    model_byte("7"); send_byte("7");
    model_byte(" "); send_byte(" ");
    checks++;
    if ({stk_wen, stk_pop_cnt, stk_din} !== {1'b1, 2'd0, 16'd7}) begin
      errors++;
      $display("FAIL latency_push got %b/%0d/%0d required 1/0/7", stk_wen, stk_pop_cnt, stk_din);
    end
    model_byte("8"); send_byte("8");
    model_byte("+"); send_byte("+");
    @(negedge clk);
    checks++;
    if (stk_wen !== 1'b0) begin errors++; $display("FAIL latency_op_gap got wen=%b required 0", stk_wen); end
    @(negedge clk);
    checks++;
    if ({stk_wen, stk_pop_cnt, stk_din} !== {1'b1, 2'd2, 16'd15}) begin
      errors++;
      $display("FAIL latency_op got %b/%0d/%0d required 1/2/15", stk_wen, stk_pop_cnt, stk_din);
    end
    end_run("latency");
  endtask

  task automatic test_emit_hold();
    int n = 0;
    ready_mode = 0;
    do_reset();
    send_byte("9");
    send_byte("=");
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_data !== 16'd9 || rx_ready !== 1'b0) begin
        errors++;
        $display("FAIL emit_hold[%0d] got v=%b d=%0d rdy=%b required 1/9/0", i, res_valid, res_data, rx_ready);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if (res_valid !== 1'b0 || rx_ready !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL emit_reset got v=%b rdy=%b err=%b required 0/1/0", res_valid, rx_ready, err);
    end
    ready_mode = 1;
    run_string("=", "emit_reset_depth0");
    run_string("c", "emit_reset_clear");
  endtask

  task automatic test_random();
    string      s;
    int         len, k;
    logic [7:0] b;
    ready_mode = 2;
    do_reset();
    for (int t = 0; t < 30; t++) begin
      s   = "";
      len = $urandom_range(6, 24);
      for (int i = 0; i < len; i++) begin
        k = $urandom_range(0, 99);
        if (k < 40)      b = 8'h30 + 8'($urandom_range(0, 9));
        else if (k < 55) b = 8'h20;
        else if (k < 59) b = (k < 57) ? 8'h0D : 8'h0A;
        else if (k < 66) b = 8'h2B;
        else if (k < 72) b = 8'h2D;
        else if (k < 78) b = 8'h2A;
        else if (k < 87) b = 8'h3D;
        else if (k < 89) b = 8'h63;
        else             b = (k < 94) ? 8'h78 : 8'h2F;
        s = {s, string'(b)};
      end
      run_string(s, $sformatf("random%0d", t));
    end
    ready_mode = 1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_string("1 2 3 4 5 6 7 8 9 10 11 12 13 14 15 16++++++=**=-=", "back_to_back");
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog expired required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_sub_wrap();
    test_mul();
    test_underflow();
    test_overflow();
    test_latency();
    test_emit_hold();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
